pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
Parametrised PLL supervisor and reset sequencer. It runs on the PLL reference clock and drives the PLL reset. It qualifies the PLL lock indication, then releases NUM_CH downstream domain resets in order, ch0 first. It retries the PLL on lock timeout, re-sequences on lock loss, and flags a fault once the retry limit is exhausted. It sits beside each EHXPLLL instance in the ethernet top level.

Parameters:
NUM_CH, 4, number of sequenced reset outputs; must be >= 1.
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt; must be >= 1.
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release.
CH_GAP_CYCLES, 16, cycles between successive channel releases; must be >= 1.
LOCK_TIMEOUT_CYCLES, 65536, cycle budget per attempt, counted from leaving PLL_RST until the lock is qualified.
MAX_RETRY, 3, PLL reset retries allowed before FAULT.

Ports:
clki  in  1  reference clock (PLL CLKI)
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL LOCK, asynchronous to clki
soft_rst  in  1  synchronous pulse; restarts the full sequence
pll_rst  out  1  to PLL RST, active high
ch_rst_n  out  NUM_CH  per-domain reset, active low
all_ready  out  1  all channels released, PLL running
fault  out  1  retry limit exhausted; sticky until rst_n or soft_rst
retry_cnt  out  clog2(MAX_RETRY+1)  retries used in the current sequence
lock_loss_cnt  out  16  lock-loss event count (see Optional Feature)

Behaviour:
- One clock domain: clki.
- Reset is asynchronous and active-low (rst_n).
- All outputs are registered.
- Reset values:
  - pll_rst=1, ch_rst_n=all 0, all_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0.
  - FSM=PLL_RST with counters at 0.
- pll_locked passes through a 2-flop synchroniser to give lk. lk lags the input by 2 cycles. Only lk is used below.
- The FSM has six states:
  - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK. The timeout counter clears on exit.
  - WAIT_LOCK: pll_rst=0. The timeout counter increments each cycle. lk=1 -> STABLE with the stable counter at 0.
  - STABLE: the stable counter increments while lk=1, and the timeout counter keeps running.
    - lk=0 -> WAIT_LOCK; the stable counter clears.
    - Stable count reaching LOCK_STABLE_CYCLES -> RELEASE.
  - Timeout, in WAIT_LOCK or STABLE: when the timeout counter reaches LOCK_TIMEOUT_CYCLES:
    - if retry_cnt < MAX_RETRY: retry_cnt+1, go to PLL_RST;
    - otherwise go to FAULT.
    - Timeout wins over lk=1 in the same cycle.
  - RELEASE: ch_rst_n[0] goes high on entry. ch_rst_n[i] goes high CH_GAP_CYCLES after ch_rst_n[i-1]. CH_GAP_CYCLES after ch_rst_n[NUM_CH-1] goes high, go to RUN.
  - RUN: all_ready=1.
  - FAULT: pll_rst=1, ch_rst_n=0, all_ready=0, fault=1. The FSM holds here until soft_rst or rst_n.
- Lock loss: lk=0 in RELEASE or RUN is a lock-loss event.
  - Next cycle: ch_rst_n=0 (all channels), all_ready=0, FSM=PLL_RST, retry_cnt=0.
  - lock_loss_cnt increments on the event.
- soft_rst=1 in any state: next cycle matches the reset values, except lock_loss_cnt, which is held.
  - soft_rst has priority over every other transition.
- retry_cnt clears on rst_n, soft_rst or lock loss. It holds its value in RUN to show how many retries the last bring-up needed.
- ch_rst_n bits never release out of order. All bits assert together in the same cycle.
- Counter widths are clog2 of their limit + 1. Counters never wrap.

Optional Feature:
Macro PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_cnt is a 16-bit counter of lock-loss events. It saturates at 0xFFFF and clears only on rst_n.
- Undefined: lock_loss_cnt is tied to 0 and no counter logic is built.
- The port exists in both builds.

Test Plan:
All scenarios use NUM_CH=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, CH_GAP_CYCLES=2, LOCK_TIMEOUT_CYCLES=32, MAX_RETRY=2.
1. Release rst_n with pll_locked=1 constantly -> pll_rst high for 4 cycles. ch_rst_n[0], [1], [2] then rise 2 cycles apart, in order, after 8 stable cycles plus 2 sync cycles. all_ready rises 2 cycles after ch_rst_n[2]. retry_cnt=0.
2. Hold pll_locked=0 -> 3 pll_rst pulses of 4 cycles each, 32 cycles apart. retry_cnt reads 1 then 2. fault=1 and pll_rst=1 are held after the third timeout. soft_rst then clears fault and retry_cnt.
3. In RUN, drop pll_locked for 1 cycle -> 2 cycles later ch_rst_n=000 and all_ready=0 together. pll_rst pulses and the full sequence repeats. With the macro defined, lock_loss_cnt=1.
4. In STABLE, glitch pll_locked low at stable count 5 -> the stable counter restarts. Release happens only after 8 consecutive locked cycles, with no pll_rst pulse.
5. Assert rst_n low mid-RELEASE, after ch_rst_n=001 -> all outputs immediately return to their reset values (asynchronous).
6. Build with the macro undefined and repeat scenario 3 -> lock_loss_cnt stays 0.

Source files
------------

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
//
// PLL supervisor and reset sequencer. Runs on the PLL reference clock, holds
// the PLL in reset, qualifies its lock indication, then releases NUM_CH
// downstream domain resets one after another (ch0 first). A PLL that fails to
// lock within the cycle budget is retried, up to MAX_RETRY times, before the
// block parks in a sticky fault. Losing lock after release pulls every
// channel back into reset and restarts the whole bring-up.
//
// Ports:
//   clki          in   reference clock (PLL CLKI)
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL LOCK, asynchronous to clki (synchronised here)
//   soft_rst      in   synchronous pulse, restarts the full sequence
//   pll_rst       out  PLL RST, active high
//   ch_rst_n      out  per-domain resets, active low, released in order
//   all_ready     out  every channel released and PLL running
//   fault         out  retry limit exhausted (sticky until rst_n/soft_rst)
//   retry_cnt     out  PLL retries used by the current bring-up
//   lock_loss_cnt out  number of lock-loss events
//
// Build option:
//   PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN - when defined, lock_loss_cnt is a
//   saturating 16-bit event counter cleared only by rst_n. When undefined the
//   port is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int NUM_CH              = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CH_GAP_CYCLES       = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY           = 3
) (
    input  logic                           clki,
    input  logic                           rst_n,
    input  logic                           pll_locked,
    input  logic                           soft_rst,
    output logic                           pll_rst,
    output logic [NUM_CH-1:0]              ch_rst_n,
    output logic                           all_ready,
    output logic                           fault,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [15:0]                    lock_loss_cnt
);

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GW = $clog2(CH_GAP_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    // Terminal values: each counter acts on the edge where it would reach its
    // limit, so it never has to hold (or wrap past) the limit itself.
    localparam logic [PW-1:0]     PRST_LAST = PW'(PLL_RST_CYCLES - 1);
    localparam logic [SW-1:0]     STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0]     GAP_LAST  = GW'(CH_GAP_CYCLES - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [NUM_CH-1:0] CH_FIRST  = NUM_CH'(1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t              state_q;
    logic                sync_q;
    logic                lk_q;
    logic [PW-1:0]       rst_cnt_q;
    logic [TW-1:0]       tmo_cnt_q;
    logic [SW-1:0]       stab_cnt_q;
    logic [GW-1:0]       gap_cnt_q;
    logic                pll_rst_q;
    logic [NUM_CH-1:0]   ch_rst_n_q;
    logic                all_ready_q;
    logic                fault_q;
    logic [RW-1:0]       retry_q;

    logic                tmo_hit;
    logic                retry_ok;

    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
    assign retry_ok = (retry_q < RETRY_MAX);

    // Two-flop synchroniser for the asynchronous PLL lock; only lk_q is used.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            lk_q   <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lk_q   <= sync_q;
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stab_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pll_rst_q   <= 1'b1;
            ch_rst_n_q  <= '0;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else if (soft_rst) begin
            state_q     <= S_PLL_RST;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stab_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pll_rst_q   <= 1'b1;
            ch_rst_n_q  <= '0;
            all_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (rst_cnt_q == PRST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        pll_rst_q <= 1'b0;
                        tmo_cnt_q <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end

                // Both qualification states share the attempt budget; the
                // timeout is checked first so it beats a same-cycle lock.
                S_WAIT_LOCK, S_STABLE: begin
                    if (tmo_hit) begin
                        if (retry_ok) begin
                            retry_q   <= retry_q + 1'b1;
                            state_q   <= S_PLL_RST;
                            rst_cnt_q <= '0;
                            pll_rst_q <= 1'b1;
                        end else begin
                            state_q   <= S_FAULT;
                            pll_rst_q <= 1'b1;
                            fault_q   <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (state_q == S_WAIT_LOCK) begin
                            if (lk_q) begin
                                state_q    <= S_STABLE;
                                stab_cnt_q <= '0;
                            end
                        end else if (!lk_q) begin
                            state_q    <= S_WAIT_LOCK;
                            stab_cnt_q <= '0;
                        end else if (stab_cnt_q == STAB_LAST) begin
                            state_q    <= S_RELEASE;
                            ch_rst_n_q <= CH_FIRST;
                            gap_cnt_q  <= '0;
                        end else begin
                            stab_cnt_q <= stab_cnt_q + 1'b1;
                        end
                    end
                end

                // ch_rst_n fills from bit 0 upward, so release order is
                // guaranteed by construction; the top bit marks the last one.
                S_RELEASE: begin
                    if (!lk_q) begin
                        state_q     <= S_PLL_RST;
                        rst_cnt_q   <= '0;
                        pll_rst_q   <= 1'b1;
                        ch_rst_n_q  <= '0;
                        all_ready_q <= 1'b0;
                        retry_q     <= '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        if (ch_rst_n_q[NUM_CH-1]) begin
                            state_q     <= S_RUN;
                            all_ready_q <= 1'b1;
                        end else begin
                            ch_rst_n_q <= (ch_rst_n_q << 1) | CH_FIRST;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                // retry_q is deliberately left alone here so software can see
                // how many attempts the last bring-up needed.
                S_RUN: begin
                    if (!lk_q) begin
                        state_q     <= S_PLL_RST;
                        rst_cnt_q   <= '0;
                        pll_rst_q   <= 1'b1;
                        ch_rst_n_q  <= '0;
                        all_ready_q <= 1'b0;
                        retry_q     <= '0;
                    end
                end

                S_FAULT: begin
                    pll_rst_q   <= 1'b1;
                    ch_rst_n_q  <= '0;
                    all_ready_q <= 1'b0;
                    fault_q     <= 1'b1;
                end

                default: begin
                    state_q   <= S_PLL_RST;
                    rst_cnt_q <= '0;
                    pll_rst_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    logic [15:0] loss_cnt_q;
    logic        loss_evt;

    // Same condition the FSM uses to abandon RELEASE/RUN; a coincident
    // soft_rst takes precedence, so that cycle is not counted as a loss.
    assign loss_evt = !soft_rst && !lk_q && (state_q == S_RELEASE || state_q == S_RUN);

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (loss_evt && (loss_cnt_q != 16'hFFFF)) begin
            loss_cnt_q <= loss_cnt_q + 16'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    assign lock_loss_cnt = 16'h0000;
`endif

    assign pll_rst   = pll_rst_q;
    assign ch_rst_n  = ch_rst_n_q;
    assign all_ready = all_ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Directed bench for pll_reset_seq with NUM_CH=3, PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, CH_GAP_CYCLES=2, LOCK_TIMEOUT_CYCLES=32, MAX_RETRY=2.
// A time-based reference model (pulse age, attempt age, consecutive-lock run
// length, time since release) predicts every output each cycle; literal
// expectations at chosen cycles pin the model.
// ---------------------------------------------------------------------------
module tb_pll_reset_seq;

    localparam int NCH  = 3;
    localparam int PRST = 4;
    localparam int STAB = 8;
    localparam int GAP  = 2;
    localparam int TMO  = 32;
    localparam int MAXR = 2;
    localparam int RW   = $clog2(MAXR + 1);

`ifdef PLL_RESET_SEQ_LOCK_LOSS_COUNT_EN
    localparam bit LL_EN = 1'b1;
`else
    localparam bit LL_EN = 1'b0;
`endif

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b1;
    logic            pll_locked = 1'b0;
    logic            soft_rst   = 1'b0;
    logic            pll_rst;
    logic [NCH-1:0]  ch_rst_n;
    logic            all_ready;
    logic            fault;
    logic [RW-1:0]   retry_cnt;
    logic [15:0]     lock_loss_cnt;

    int errors = 0;
    int checks = 0;

    pll_reset_seq #(
        .NUM_CH              (NCH),
        .PLL_RST_CYCLES      (PRST),
        .LOCK_STABLE_CYCLES  (STAB),
        .CH_GAP_CYCLES       (GAP),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRY           (MAXR)
    ) dut (
        .clki          (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_rst      (soft_rst),
        .pll_rst       (pll_rst),
        .ch_rst_n      (ch_rst_n),
        .all_ready     (all_ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // pulse_age : edges since the current PLL reset pulse began
    // att_age   : edges since that pulse ended (attempt budget)
    // run_len   : consecutive synced-lock edges in this attempt; the edge that
    //             first sees lock does not count toward the stable window,
    //             so release needs STAB+1 of them
    // rel_age   : edges since the lock was qualified (saturates)
    int pulse_age, att_age, run_len, rel_age, retries, losses;
    bit released, faulted;
    bit h0, h1;  // pll_locked seen one and two edges ago

    task automatic restart();
        pulse_age = 0;
        att_age   = 0;
        run_len   = 0;
        rel_age   = 0;
        released  = 1'b0;
    endtask

    task automatic model_reset();
        restart();
        retries = 0;
        losses  = 0;
        faulted = 1'b0;
        h0      = 1'b0;
        h1      = 1'b0;
    endtask

    task automatic model_step();
        bit lk;
        lk = h1;
        h1 = h0;
        h0 = pll_locked;
        if (soft_rst) begin
            restart();
            retries = 0;
            faulted = 1'b0;
        end else if (faulted) begin
            faulted = 1'b1;
        end else if (released) begin
            if (!lk) begin
                restart();
                retries = 0;
                if (LL_EN && losses < 65535) losses++;
            end else if (rel_age < NCH * GAP) begin
                rel_age++;
            end
        end else if (pulse_age < PRST) begin
            pulse_age++;
            att_age = 0;
            run_len = 0;
        end else begin
            att_age++;
            if (att_age == TMO) begin
                if (retries < MAXR) begin
                    retries++;
                    restart();
                end else begin
                    faulted = 1'b1;
                end
            end else begin
                run_len = lk ? run_len + 1 : 0;
                if (run_len == STAB + 1) begin
                    released = 1'b1;
                    rel_age  = 0;
                end
            end
        end
    endtask

    function automatic logic exp_pll_rst();
        return faulted || (!released && pulse_age < PRST);
    endfunction

    function automatic logic [NCH-1:0] exp_ch();
        logic [NCH-1:0] e;
        e = '0;
        for (int i = 0; i < NCH; i++)
            e[i] = !faulted && released && (rel_age >= i * GAP);
        return e;
    endfunction

    function automatic logic exp_ready();
        return !faulted && released && (rel_age >= NCH * GAP);
    endfunction

    function automatic logic [15:0] exp_ll();
        return LL_EN ? 16'(losses) : 16'h0000;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        checks++;
        if (pll_rst !== exp_pll_rst() || ch_rst_n !== exp_ch() ||
            all_ready !== exp_ready() || fault !== faulted ||
            retry_cnt !== RW'(retries) || lock_loss_cnt !== exp_ll()) begin
            errors++;
            $display("FAIL model t=%0t got pll_rst=%b ch_rst_n=%b all_ready=%b fault=%b retry_cnt=%0d lock_loss_cnt=%0d need %b %b %b %b %0d %0d",
                     $time, pll_rst, ch_rst_n, all_ready, fault, retry_cnt, lock_loss_cnt,
                     exp_pll_rst(), exp_ch(), exp_ready(), faulted, retries, exp_ll());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h need=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Advance n active edges, then park on the following inactive edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_soft(input logic locked);
        soft_rst   = 1'b1;
        pll_locked = locked;
        step(1);
        soft_rst   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        step(1);
        lit("reset pll_rst",   32'(pll_rst),       32'd1);
        lit("reset ch_rst_n",  32'(ch_rst_n),      32'd0);
        lit("reset all_ready", 32'(all_ready),     32'd0);
        lit("reset fault",     32'(fault),         32'd0);
        lit("reset retry_cnt", 32'(retry_cnt),     32'd0);
        lit("reset llc",       32'(lock_loss_cnt), 32'd0);

        // 1: clean bring-up with lock present throughout
        pll_locked = 1'b1;
        rst_n      = 1'b1;
        step(3);  lit("s1 pll_rst e3",   32'(pll_rst),   32'd1);
        step(1);  lit("s1 pll_rst e4",   32'(pll_rst),   32'd0);
        step(8);  lit("s1 ch e12",       32'(ch_rst_n),  32'b000);
        step(1);  lit("s1 ch e13",       32'(ch_rst_n),  32'b001);
        step(2);  lit("s1 ch e15",       32'(ch_rst_n),  32'b011);
        step(2);  lit("s1 ch e17",       32'(ch_rst_n),  32'b111);
                  lit("s1 ready e17",    32'(all_ready), 32'd0);
        step(2);  lit("s1 ready e19",    32'(all_ready), 32'd1);
                  lit("s1 retry",        32'(retry_cnt), 32'd0);

        // 2: no lock -> two retries, then fault; soft_rst clears it
        pulse_soft(1'b0);
        lit("s2 pll_rst S",   32'(pll_rst),   32'd1);
        lit("s2 ch S",        32'(ch_rst_n),  32'd0);
        step(35); lit("s2 pll_rst S+35", 32'(pll_rst),   32'd0);
                  lit("s2 retry S+35",   32'(retry_cnt), 32'd0);
        step(1);  lit("s2 pll_rst S+36", 32'(pll_rst),   32'd1);
                  lit("s2 retry S+36",   32'(retry_cnt), 32'd1);
        step(4);  lit("s2 pll_rst S+40", 32'(pll_rst),   32'd0);
        step(32); lit("s2 retry S+72",   32'(retry_cnt), 32'd2);
                  lit("s2 pll_rst S+72", 32'(pll_rst),   32'd1);
        step(35); lit("s2 fault S+107",  32'(fault),     32'd0);
        step(1);  lit("s2 fault S+108",  32'(fault),     32'd1);
                  lit("s2 pll_rst S+108", 32'(pll_rst),  32'd1);
        step(10); lit("s2 fault held",   32'(fault),     32'd1);
                  lit("s2 pll_rst held", 32'(pll_rst),   32'd1);

        // 3: soft_rst with lock back, reach RUN, then a one-cycle lock drop
        pulse_soft(1'b1);
        lit("s3 fault cleared", 32'(fault),     32'd0);
        lit("s3 retry cleared", 32'(retry_cnt), 32'd0);
        step(19); lit("s3 ready",        32'(all_ready), 32'd1);
                  lit("s3 ch",           32'(ch_rst_n),  32'b111);
        step(3);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);  lit("s3 ready D+1",    32'(all_ready), 32'd1);
        step(1);  lit("s3 ch D+2",       32'(ch_rst_n),  32'b000);
                  lit("s3 ready D+2",    32'(all_ready), 32'd0);
                  lit("s3 pll_rst D+2",  32'(pll_rst),   32'd1);
                  lit("s3 llc D+2",      32'(lock_loss_cnt), LL_EN ? 32'd1 : 32'd0);
        step(18); lit("s3 ch D+20",      32'(ch_rst_n),  32'b111);
                  lit("s3 ready D+20",   32'(all_ready), 32'd0);
        step(1);  lit("s3 ready D+21",   32'(all_ready), 32'd1);

        // 4: lock glitch at stable count 5 restarts the stable window
        pulse_soft(1'b1);
        lit("s4 llc held", 32'(lock_loss_cnt), LL_EN ? 32'd1 : 32'd0);
        step(8);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(4);  lit("s4 ch S+13",      32'(ch_rst_n),  32'b000);
        step(6);  lit("s4 ch S+19",      32'(ch_rst_n),  32'b000);
                  lit("s4 pll_rst S+19", 32'(pll_rst),   32'd0);
        step(1);  lit("s4 ch S+20",      32'(ch_rst_n),  32'b001);

        // 5: asynchronous reset in the middle of RELEASE
        pulse_soft(1'b1);
        step(13); lit("s5 ch S+13",      32'(ch_rst_n),  32'b001);
        step(1);  lit("s5 ch S+14",      32'(ch_rst_n),  32'b001);
        #2 rst_n = 1'b0;
        #1;
        lit("s5 async pll_rst",   32'(pll_rst),       32'd1);
        lit("s5 async ch",        32'(ch_rst_n),      32'd0);
        lit("s5 async ready",     32'(all_ready),     32'd0);
        lit("s5 async retry",     32'(retry_cnt),     32'd0);
        lit("s5 async llc",       32'(lock_loss_cnt), 32'd0);

        // retry count survives into RUN after a late lock
        @(negedge clk);
        pll_locked = 1'b0;
        rst_n      = 1'b1;
        step(36); lit("s6 retry e36",    32'(retry_cnt), 32'd1);
                  lit("s6 pll_rst e36",  32'(pll_rst),   32'd1);
        step(4);  lit("s6 pll_rst e40",  32'(pll_rst),   32'd0);
        pll_locked = 1'b1;
        step(16); lit("s6 ready e56",    32'(all_ready), 32'd0);
        step(1);  lit("s6 ready e57",    32'(all_ready), 32'd1);
                  lit("s6 retry e57",    32'(retry_cnt), 32'd1);
        step(5);  lit("s6 retry held",   32'(retry_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
